prog_shift_delay: RTL and testbench
===================================

PROG_SHIFT_DELAY -- requirements
Module: prog_shift_delay

Interface
REQ-001 SHALL have parameter MAX_DELAY, default 64: maximum delay in steps (clock cycles or accepted samples), range 2..4096.
REQ-002 SHALL have parameter DW, default 16: signed sample width per channel.
REQ-003 SHALL have parameter NCH, default 2: channel count; all channels share the same delay and valid.
REQ-004 SHALL have parameter GATED, default 0: 0 = delay counted in clock cycles; 1 = delay counted in accepted samples (d_in_val high).
REQ-005 SHALL have parameter DEF_DELAY, default 8: active delay after reset, range 1..MAX_DELAY.
REQ-006 SHALL define AW = $clog2(MAX_DELAY+1) for the delay_cfg width.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port delay_cfg, input, AW: requested delay, sampled only when cfg_load is high.
REQ-010 SHALL have port cfg_load, input, 1: one-cycle pulse that applies delay_cfg.
REQ-011 SHALL have port d_in, input, NCH*DW: signed samples; channel k occupies bits [k*DW +: DW].
REQ-012 SHALL have port d_in_val, input, 1: input sample valid.
REQ-013 SHALL have port d_out, output, NCH*DW: delayed samples, same packing as d_in.
REQ-014 SHALL have port d_out_val, output, 1: delayed valid.
REQ-015 SHALL have port primed, output, 1: high when the line is in state RUN.

Function
REQ-016 SHALL implement a circular buffer of MAX_DELAY entries per channel, with a write pointer and a read pointer equal to the write pointer minus the active delay D, modulo MAX_DELAY.
REQ-017 SHALL clamp a loaded delay_cfg of 0 to 1 and values above MAX_DELAY to MAX_DELAY.
REQ-018 SHALL, with GATED=0, write every cycle, and in RUN give d_out(t) = d_in(t-D) and d_out_val(t) = d_in_val(t-D), so the total latency is exactly D cycles.
REQ-019 SHALL, with GATED=1, write and advance only when d_in_val is high.
REQ-020 SHALL, with GATED=1 in RUN, present on d_out one cycle after each accepted input the sample accepted D acceptances earlier, pulse d_out_val for that cycle, and hold d_out otherwise.
REQ-021 SHALL use a state machine of three states: IDLE, FILL and RUN.
REQ-022 SHALL enter IDLE on reset and move from IDLE to FILL on the next cycle.
REQ-023 SHALL, in FILL, count steps (cycles for GATED=0, accepted samples for GATED=1) and move to RUN once D steps have been written.
REQ-024 SHALL, in RUN, remain in RUN until cfg_load or rst.
REQ-025 SHALL, on cfg_load in any state, latch the clamped delay_cfg as D, clear the fill count and enter FILL, including when the value equals the current D.
REQ-026 SHALL count a sample accepted in the same cycle as cfg_load as the first fill step under the new D.
REQ-027 SHALL force d_out = 0 and d_out_val = 0 in IDLE and FILL, so that no stale or mixed-delay data is ever marked valid.
REQ-028 SHALL keep primed = 1 only in RUN, dropping it the cycle after cfg_load.
REQ-029 SHALL treat D = MAX_DELAY as legal, reading the entry about to be overwritten before it is overwritten.
REQ-030 SHALL wrap both pointers from MAX_DELAY-1 to 0 with no gap or duplicated sample.
REQ-031 SHALL pass data through unmodified, with no sign change or width change.

Reset
REQ-032 SHALL, on rst high at a clock edge, clear both pointers and the fill count, set D = DEF_DELAY, enter IDLE, and drive d_out = 0, d_out_val = 0 and primed = 0 from the next cycle.
REQ-033 SHALL give rst priority over a simultaneous cfg_load, which is ignored.
REQ-034 SHALL, on rst mid-FILL or mid-RUN, abandon the fill and discard any in-flight samples, none of which may appear valid afterwards.
REQ-035 SHALL not require the buffer contents to be cleared on reset, since REQ-027 masks them.

Verification
REQ-036 SHALL verify, with GATED=0 and DEF_DELAY=8: ramp input 1,2,3,... with d_in_val = 1 -> primed rises 8 cycles after FILL entry, and d_out equals the input from 8 cycles earlier with d_out_val = 1.
REQ-037 SHALL verify, with GATED=0: cfg_load delay_cfg=3 during RUN -> primed = 0 and d_out_val = 0 for 3 cycles, then the delay is 3, with no sample from the old delay ever valid.
REQ-038 SHALL verify, with GATED=1 and D=4: d_in_val high every 3rd cycle carrying values 10,20,30,... -> first d_out_val with d_out = 10 one cycle after the 5th acceptance (value 50), then 20 after the 6th.
REQ-039 SHALL verify clamping and wrap: delay_cfg = 0 -> D = 1; delay_cfg = MAX_DELAY+5 -> D = MAX_DELAY; run at least 3*MAX_DELAY steps with no mismatch across pointer wrap.
REQ-040 SHALL verify reset and priority: rst with cfg_load in the same cycle -> D = DEF_DELAY; rst mid-RUN -> all outputs 0 the next cycle, and refill takes DEF_DELAY steps.
REQ-041 SHALL verify channel independence with NCH=3: distinct signed patterns per channel, including -2^(DW-1) and 2^(DW-1)-1 -> each channel is delayed intact with no lane crossover.

Source files
------------

// File: rtl/prog_shift_delay.sv
// prog_shift_delay: programmable multi-channel delay line built on a circular buffer.
// The read pointer trails the write pointer by the active delay. Outputs are masked
// until the buffer has been refilled under the current delay. A refill starts after
// reset and after every cfg_load.
// GATED=0: the delay is counted in clock cycles.
// GATED=1: the delay is counted in accepted samples (d_in_val high).

module prog_shift_delay #(
    parameter int MAX_DELAY = 64,
    parameter int DW        = 16,
    parameter int NCH       = 2,
    parameter int GATED     = 0,
    parameter int DEF_DELAY = 8,
    localparam int AW       = $clog2(MAX_DELAY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     delay_cfg,
    input  logic              cfg_load,
    input  logic [NCH*DW-1:0] d_in,
    input  logic              d_in_val,
    output logic [NCH*DW-1:0] d_out,
    output logic              d_out_val,
    output logic              primed
);

    localparam int PW = $clog2(MAX_DELAY);
    localparam int TW = AW + 1;
    localparam int WW = NCH * DW;
    localparam bit IS_GATED = (GATED != 0);

    localparam logic [AW-1:0] DEF_D    = AW'(DEF_DELAY);
    localparam logic [AW-1:0] MAX_D    = AW'(MAX_DELAY);
    localparam logic [AW-1:0] ONE_D    = AW'(1'b1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_DELAY - 1);
    localparam logic [TW-1:0] MAX_T    = TW'(MAX_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   delay_r;
    logic [AW-1:0]   fill_r;
    logic [PW-1:0]   wr_ptr_r;

    logic [WW-1:0]   mem_r     [MAX_DELAY];
    logic            val_mem_r [MAX_DELAY];

    logic            step_s;
    logic [AW-1:0]   cfg_clamp_s;
    logic [AW-1:0]   fill_inc_s;
    logic            fill_done_s;
    logic [TW-1:0]   rd_sum_s;
    logic [PW-1:0]   rd_ptr_s;
    logic [WW-1:0]   rd_data_s;
    logic            rd_val_s;

    // A step is one clock cycle in cycle mode, one accepted sample in gated mode.
    always_comb begin
        if (IS_GATED) begin
            step_s = d_in_val;
        end else begin
            step_s = 1'b1;
        end
    end

    // Clamp the requested delay into the legal range 1..MAX_DELAY.
    always_comb begin
        if (delay_cfg == {AW{1'b0}}) begin
            cfg_clamp_s = ONE_D;
        end else if (delay_cfg > MAX_D) begin
            cfg_clamp_s = MAX_D;
        end else begin
            cfg_clamp_s = delay_cfg;
        end
    end

    // The fill is complete on the step that brings the count up to the active delay.
    always_comb begin
        fill_inc_s  = fill_r + ONE_D;
        fill_done_s = (fill_inc_s == delay_r);
    end

    // Read pointer = write pointer - D (mod MAX_DELAY). Gated mode reads that entry at
    // the acceptance edge. Cycle mode registers the output one cycle early, so it looks
    // one entry ahead to keep the total latency at exactly D cycles.
    always_comb begin
        rd_sum_s = TW'(wr_ptr_r) + MAX_T - {1'b0, delay_r}
                 + (IS_GATED ? {TW{1'b0}} : TW'(1'b1));
        if (rd_sum_s >= MAX_T) begin
            rd_ptr_s = PW'(rd_sum_s - MAX_T);
        end else begin
            rd_ptr_s = PW'(rd_sum_s);
        end
    end

    // Cycle mode with D=1 must forward the sample being written in this cycle.
    // Every other case reads from the buffer. With D=MAX_DELAY in gated mode, the
    // buffer read returns the old entry before this edge overwrites it.
    always_comb begin
        if (!IS_GATED && (delay_r == ONE_D)) begin
            rd_data_s = d_in;
            rd_val_s  = d_in_val;
        end else begin
            rd_data_s = mem_r[rd_ptr_s];
            rd_val_s  = val_mem_r[rd_ptr_s];
        end
    end

    // Sample storage. The buffer is never cleared; the output masking hides stale entries.
    always_ff @(posedge clk) begin
        if (step_s) begin
            mem_r[wr_ptr_r]     <= d_in;
            val_mem_r[wr_ptr_r] <= d_in_val;
        end
    end

    // Write pointer advances on every step and wraps from MAX_DELAY-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
        end else if (step_s) begin
            if (wr_ptr_r == LAST_PTR) begin
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
        end
    end

    // Line control FSM (IDLE -> FILL -> RUN) with its registered outputs.
    // Reset takes priority over cfg_load. cfg_load restarts the fill from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            delay_r   <= DEF_D;
            fill_r    <= {AW{1'b0}};
            d_out     <= {WW{1'b0}};
            d_out_val <= 1'b0;
            primed    <= 1'b0;
        end else if (cfg_load) begin
            delay_r   <= cfg_clamp_s;
            d_out     <= {WW{1'b0}};
            d_out_val <= 1'b0;
            if (IS_GATED && d_in_val) begin
                // The sample accepted alongside cfg_load is the first fill step.
                fill_r <= ONE_D;
                if (cfg_clamp_s == ONE_D) begin
                    state_r <= ST_RUN;
                    primed  <= 1'b1;
                end else begin
                    state_r <= ST_FILL;
                    primed  <= 1'b0;
                end
            end else begin
                fill_r  <= {AW{1'b0}};
                state_r <= ST_FILL;
                primed  <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r   <= ST_FILL;
                    fill_r    <= {AW{1'b0}};
                    d_out     <= {WW{1'b0}};
                    d_out_val <= 1'b0;
                    primed    <= 1'b0;
                end
                ST_FILL: begin
                    if (step_s) begin
                        fill_r <= fill_inc_s;
                        if (fill_done_s) begin
                            state_r <= ST_RUN;
                            primed  <= 1'b1;
                            if (!IS_GATED) begin
                                d_out     <= rd_data_s;
                                d_out_val <= rd_val_s;
                            end else begin
                                d_out     <= {WW{1'b0}};
                                d_out_val <= 1'b0;
                            end
                        end else begin
                            d_out     <= {WW{1'b0}};
                            d_out_val <= 1'b0;
                        end
                    end else begin
                        d_out     <= {WW{1'b0}};
                        d_out_val <= 1'b0;
                    end
                end
                ST_RUN: begin
                    primed <= 1'b1;
                    if (!IS_GATED) begin
                        d_out     <= rd_data_s;
                        d_out_val <= rd_val_s;
                    end else if (d_in_val) begin
                        d_out     <= rd_data_s;
                        d_out_val <= 1'b1;
                    end else begin
                        d_out_val <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    fill_r    <= {AW{1'b0}};
                    d_out     <= {WW{1'b0}};
                    d_out_val <= 1'b0;
                    primed    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_shift_delay.sv
// Testbench for prog_shift_delay. Two instances share one stimulus stream.
// Instance a is cycle-counted (GATED=0); instance b is sample-counted (GATED=1).
// Each instance is compared against a history-queue model every cycle.

module tb_prog_shift_delay;

    localparam int MAXD = 16;
    localparam int DW   = 16;
    localparam int NCH  = 3;
    localparam int DEFD = 8;
    localparam int AW   = $clog2(MAXD + 1);
    localparam int WW   = NCH * DW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] delay_cfg;
    logic          cfg_load;
    logic [WW-1:0] d_in;
    logic          d_in_val;
    logic [WW-1:0] a_out, b_out;
    logic          a_val, b_val, a_primed, b_primed;

    int checks = 0;
    int errors = 0;

    // Reference model state. A step counter below 0 means idle. Output is valid once the
    // counted steps since the last (re)start reach D.
    int            a_d, a_steps;
    logic [WW-1:0] a_hd[$];
    logic          a_hv[$];
    logic [WW+1:0] exp_a;
    int            b_d, b_steps;
    logic [WW-1:0] b_hd[$];
    logic [WW+1:0] exp_b;

    prog_shift_delay #(.MAX_DELAY(MAXD), .DW(DW), .NCH(NCH), .GATED(0), .DEF_DELAY(DEFD)) u_a (
        .clk(clk), .rst(rst), .delay_cfg(delay_cfg), .cfg_load(cfg_load),
        .d_in(d_in), .d_in_val(d_in_val), .d_out(a_out), .d_out_val(a_val), .primed(a_primed)
    );

    prog_shift_delay #(.MAX_DELAY(MAXD), .DW(DW), .NCH(NCH), .GATED(1), .DEF_DELAY(DEFD)) u_b (
        .clk(clk), .rst(rst), .delay_cfg(delay_cfg), .cfg_load(cfg_load),
        .d_in(d_in), .d_in_val(d_in_val), .d_out(b_out), .d_out_val(b_val), .primed(b_primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp_d(input logic [AW-1:0] v);
        if (v == '0) return 1;
        if (int'(v) > MAXD) return MAXD;
        return int'(v);
    endfunction

    // Cycle-counted model: d_out(t) = d_in(t-D) once D cycles of fill have elapsed.
    task automatic model_a();
        if (rst) begin
            a_d = DEFD; a_steps = -1; exp_a = '0;
            return;
        end
        a_hd.push_back(d_in);
        a_hv.push_back(d_in_val);
        if (a_hd.size() > 40) begin
            void'(a_hd.pop_front());
            void'(a_hv.pop_front());
        end
        if (cfg_load) begin
            a_d = clamp_d(delay_cfg); a_steps = 0;
        end else if (a_steps < 0) begin
            a_steps = 0;
        end else if (a_steps < 1000) begin
            a_steps++;
        end
        if (a_steps >= a_d)
            exp_a = {a_hd[a_hd.size() - a_d], a_hv[a_hv.size() - a_d], 1'b1};
        else
            exp_a = '0;
    endtask

    // Sample-counted model: each acceptance in RUN outputs the sample accepted D earlier.
    task automatic model_b();
        logic          was_run;
        logic [WW-1:0] old;
        if (rst) begin
            b_d = DEFD; b_steps = -1; exp_b = '0;
            return;
        end
        was_run = (b_steps >= b_d) && !cfg_load;
        old = (b_hd.size() >= b_d) ? b_hd[b_hd.size() - b_d] : '0;
        if (d_in_val) begin
            b_hd.push_back(d_in);
            if (b_hd.size() > 40) void'(b_hd.pop_front());
        end
        if (cfg_load) begin
            b_d = clamp_d(delay_cfg); b_steps = d_in_val ? 1 : 0;
        end else if (b_steps < 0) begin
            b_steps = 0;
        end else if (d_in_val && b_steps < 1000) begin
            b_steps++;
        end
        if (b_steps < b_d)      exp_b = '0;
        else if (!was_run)      exp_b = {{WW{1'b0}}, 1'b0, 1'b1};
        else if (d_in_val)      exp_b = {old, 1'b1, 1'b1};
        else                    exp_b = {exp_b[WW+1:2], 1'b0, 1'b1};
    endtask

    task automatic tick();
        model_a();
        model_b();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first_a, first_b;
        rst = 1'b1; cfg_load = 1'b1; delay_cfg = 5'd3; d_in_val = 1'b1;
        d_in = WW'({$urandom(), $urandom()});
        tick();
        tick();
        checks++;
        if ({a_out, a_val, a_primed, b_out, b_val, b_primed} !== '0) begin
            errors++;
            $display("FAIL reset_zero got a=%h/%b/%b b=%h/%b/%b exp all 0", a_out, a_val, a_primed, b_out, b_val, b_primed);
        end
        rst = 1'b0; cfg_load = 1'b0;
        first_a = -1; first_b = -1;
        for (int i = 1; i <= 12; i++) begin
            d_in = WW'({$urandom(), $urandom()});
            d_in_val = 1'b1;
            tick();
            checks++;
            if ({a_out, a_val, a_primed} !== exp_a) begin
                errors++; $display("FAIL reset_a got %h exp %h", {a_out, a_val, a_primed}, exp_a);
            end
            checks++;
            if ({b_out, b_val, b_primed} !== exp_b) begin
                errors++; $display("FAIL reset_b got %h exp %h", {b_out, b_val, b_primed}, exp_b);
            end
            if (a_primed && first_a < 0) first_a = i;
            if (b_primed && first_b < 0) first_b = i;
        end
        checks++;
        if (first_a !== 9 || first_b !== 9) begin
            errors++; $display("FAIL reset_fill_len got a=%0d b=%0d exp 9", first_a, first_b);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 30; i++) begin
            d_in = {16'(3000 + i), 16'(2000 + i), 16'(1000 + i)};
            d_in_val = 1'b1;
            tick();
            checks++;
            if ({a_out, a_val, a_primed} !== exp_a) begin
                errors++; $display("FAIL ramp_a got %h exp %h", {a_out, a_val, a_primed}, exp_a);
            end
            checks++;
            if ({b_out, b_val, b_primed} !== exp_b) begin
                errors++; $display("FAIL ramp_b got %h exp %h", {b_out, b_val, b_primed}, exp_b);
            end
            if (i >= 7) begin
                checks++;
                if (a_out[15:0] !== 16'(1000 + i - 7) || a_val !== 1'b1) begin
                    errors++; $display("FAIL ramp_ch0 got %0d/%b exp %0d/1", a_out[15:0], a_val, 1000 + i - 7);
                end
            end
        end
    endtask

    task automatic test_reload();
        logic [WW-1:0] drv[9];
        for (int k = 0; k < 9; k++) begin
            drv[k] = WW'({$urandom(), $urandom()});
            d_in = drv[k];
            d_in_val = 1'b1;
            cfg_load = (k == 0);
            delay_cfg = 5'd3;
            tick();
            checks++;
            if ({a_out, a_val, a_primed} !== exp_a) begin
                errors++; $display("FAIL reload_a got %h exp %h", {a_out, a_val, a_primed}, exp_a);
            end
            checks++;
            if ({b_out, b_val, b_primed} !== exp_b) begin
                errors++; $display("FAIL reload_b got %h exp %h", {b_out, b_val, b_primed}, exp_b);
            end
            checks++;
            if (k < 3) begin
                if (a_primed !== 1'b0 || a_val !== 1'b0) begin
                    errors++; $display("FAIL reload_mask k=%0d got p=%b v=%b exp 0/0", k, a_primed, a_val);
                end
            end else if (a_primed !== 1'b1 || a_out !== drv[k - 2]) begin
                errors++; $display("FAIL reload_delay k=%0d got p=%b d=%h exp 1/%h", k, a_primed, a_out, drv[k - 2]);
            end
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_gated();
        int nacc, nout;
        nacc = 0; nout = 0;
        cfg_load = 1'b1; delay_cfg = 5'd4; d_in_val = 1'b0;
        tick();
        cfg_load = 1'b0;
        for (int j = 0; j < 36; j++) begin
            d_in_val = (j % 3 == 2);
            if (d_in_val) begin
                nacc++;
                d_in = {3{16'(10 * nacc)}};
            end else begin
                d_in = WW'({$urandom(), $urandom()});
            end
            tick();
            checks++;
            if ({a_out, a_val, a_primed} !== exp_a) begin
                errors++; $display("FAIL gated_a got %h exp %h", {a_out, a_val, a_primed}, exp_a);
            end
            checks++;
            if ({b_out, b_val, b_primed} !== exp_b) begin
                errors++; $display("FAIL gated_b got %h exp %h", {b_out, b_val, b_primed}, exp_b);
            end
            if (b_val) begin
                nout++;
                checks++;
                if (b_out[15:0] !== 16'(10 * nout) || nacc !== nout + 4) begin
                    errors++; $display("FAIL gated_seq got %0d at acc %0d exp %0d at acc %0d", b_out[15:0], nacc, 10 * nout, nout + 4);
                end
            end
        end
        checks++;
        if (nout !== 8) begin
            errors++; $display("FAIL gated_count got %0d exp 8", nout);
        end
    endtask

    task automatic test_clamp_wrap();
        int first_a;
        int runs[2] = '{60, 160};
        int exp_first[2] = '{1, 16};
        logic [AW-1:0] cfgs[2] = '{5'd0, 5'(MAXD + 5)};
        for (int s = 0; s < 2; s++) begin
            first_a = -1;
            for (int k = 0; k < runs[s]; k++) begin
                cfg_load = (k == 0);
                delay_cfg = cfgs[s];
                d_in = WW'({$urandom(), $urandom()});
                d_in_val = ($urandom_range(3) != 0);
                tick();
                checks++;
                if ({a_out, a_val, a_primed} !== exp_a) begin
                    errors++; $display("FAIL wrap_a s=%0d got %h exp %h", s, {a_out, a_val, a_primed}, exp_a);
                end
                checks++;
                if ({b_out, b_val, b_primed} !== exp_b) begin
                    errors++; $display("FAIL wrap_b s=%0d got %h exp %h", s, {b_out, b_val, b_primed}, exp_b);
                end
                if (a_primed && first_a < 0) first_a = k;
            end
            checks++;
            if (first_a !== exp_first[s]) begin
                errors++; $display("FAIL clamp s=%0d got first primed %0d exp %0d", s, first_a, exp_first[s]);
            end
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_channels();
        for (int i = 0; i < 40; i++) begin
            cfg_load = (i == 0);
            delay_cfg = 5'd5;
            d_in = {((i % 4 == 0) ? 16'hFFFF : 16'($urandom())),
                    (i[0] ? 16'h8000 : 16'h7FFF),
                    (i[0] ? 16'h7FFF : 16'h8000)};
            d_in_val = ($urandom_range(1) != 0);
            tick();
            checks++;
            if ({a_out, a_val, a_primed} !== exp_a) begin
                errors++; $display("FAIL chan_a got %h exp %h", {a_out, a_val, a_primed}, exp_a);
            end
            checks++;
            if ({b_out, b_val, b_primed} !== exp_b) begin
                errors++; $display("FAIL chan_b got %h exp %h", {b_out, b_val, b_primed}, exp_b);
            end
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_rst_mid_run();
        int first_a, first_b;
        rst = 1'b1; cfg_load = 1'b1; delay_cfg = 5'd2; d_in_val = 1'b1;
        tick();
        checks++;
        if ({a_out, a_val, a_primed, b_out, b_val, b_primed} !== '0) begin
            errors++; $display("FAIL midrst_zero got a=%h/%b/%b b=%h/%b/%b exp all 0", a_out, a_val, a_primed, b_out, b_val, b_primed);
        end
        rst = 1'b0; cfg_load = 1'b0;
        first_a = -1; first_b = -1;
        for (int i = 1; i <= 12; i++) begin
            d_in = WW'({$urandom(), $urandom()});
            d_in_val = 1'b1;
            tick();
            checks++;
            if ({a_out, a_val, a_primed} !== exp_a) begin
                errors++; $display("FAIL midrst_a got %h exp %h", {a_out, a_val, a_primed}, exp_a);
            end
            checks++;
            if ({b_out, b_val, b_primed} !== exp_b) begin
                errors++; $display("FAIL midrst_b got %h exp %h", {b_out, b_val, b_primed}, exp_b);
            end
            if (a_primed && first_a < 0) first_a = i;
            if (b_primed && first_b < 0) first_b = i;
        end
        checks++;
        if (first_a !== 9 || first_b !== 9) begin
            errors++; $display("FAIL midrst_fill_len got a=%0d b=%0d exp 9", first_a, first_b);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(149) == 0);
            cfg_load = ($urandom_range(29) == 0);
            delay_cfg = AW'($urandom_range(31));
            d_in = WW'({$urandom(), $urandom()});
            d_in_val = ($urandom_range(1) != 0);
            tick();
            checks++;
            if ({a_out, a_val, a_primed} !== exp_a) begin
                errors++; $display("FAIL b2b_a i=%0d got %h exp %h", i, {a_out, a_val, a_primed}, exp_a);
            end
            checks++;
            if ({b_out, b_val, b_primed} !== exp_b) begin
                errors++; $display("FAIL b2b_b i=%0d got %h exp %h", i, {b_out, b_val, b_primed}, exp_b);
            end
        end
        rst = 1'b0; cfg_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; delay_cfg = '0; d_in = '0; d_in_val = 1'b0;
        a_d = DEFD; a_steps = -1; exp_a = '0;
        b_d = DEFD; b_steps = -1; exp_b = '0;
        test_reset();
        test_ramp();
        test_reload();
        test_gated();
        test_clamp_wrap();
        test_channels();
        test_rst_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
